weight_fetch_ctrl: RTL and testbench

//  Sequencer directly upstream of the on-chip weight read master; feeds the PE array.
//  - Accepts a fetch command (base word address, beat count).
//  - Drives the master's address/read-enable, collects the 1024-bit beats it returns,
//    and buffers them in a FIFO with valid/ready backpressure to the PE array.
//  - Pulses done once every beat of the command has been handed to the PE array.

---
 rtl/weight_fetch_ctrl.sv | 162 ++++++++++++++++
 tb/tb_weight_fetch_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_fetch_ctrl.sv
// Weight fetch sequencer: issues word reads to the weight read master and buffers returned beats
// in a FIFO for the PE array. Optional macro WEIGHT_FETCH_STALL_CNT_EN adds a FETCH stall counter.
module weight_fetch_ctrl #(
    parameter int ADDR_W     = 17,
    parameter int DATA_W     = 1024,
    parameter int LEN_W      = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic [ADDR_W-1:0] addr_read_input,
    output logic              read_en_input,
    input  logic [DATA_W-1:0] data_read,
    input  logic              data_valid,
    output logic [DATA_W-1:0] w_data,
    output logic              w_valid,
    input  logic              w_ready,
    output logic              busy,
    output logic              done,
    output logic [1:0]        fsm_state
`ifdef WEIGHT_FETCH_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    // Handshakes: a command transfers on a rising edge where cmd_valid & cmd_ready; a FIFO
    // entry transfers to the PE array on a rising edge where w_valid & w_ready. A valid
    // side may not depend combinationally on its ready.

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  rx_cnt;
    logic              done_q;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [PTR_W:0]    count;
    logic [PTR_W:0]    free_slots;

    logic accept, push, pop, last_beat, fifo_empty;

    assign accept     = (state_q == S_IDLE) && cmd_valid;
    assign fifo_empty = (count == '0);
    assign free_slots = (PTR_W+1)'(FIFO_DEPTH) - count;
    // Only beats still owed to the command are pushed; overrun beats and beats outside FETCH are dropped.
    assign push       = (state_q == S_FETCH) && data_valid && (rx_cnt != len_q);
    assign pop        = w_valid && w_ready;
    assign last_beat  = push && ((rx_cnt + LEN_W'(1)) == len_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_d = (cmd_len == '0) ? S_DRAIN : S_FETCH;
                end
            end
            S_FETCH: begin
                if (last_beat) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (fifo_empty) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            len_q  <= '0;
            rx_cnt <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= (state_q == S_DRAIN) && fifo_empty;
            if (accept) begin
                addr_q <= cmd_base;
                len_q  <= cmd_len;
                rx_cnt <= '0;
            end else if (push) begin
                addr_q <= addr_q + ADDR_W'(1);
                rx_cnt <= rx_cnt + LEN_W'(1);
            end
        end
    end

    // Beat storage carries no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_read;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Three free slots of margin absorb beats already in flight inside the read master.
    assign read_en_input   = (state_q == S_FETCH) && (free_slots >= (PTR_W+1)'(3));
    assign addr_read_input = addr_q;
    assign cmd_ready       = (state_q == S_IDLE);
    assign busy            = (state_q != S_IDLE);
    assign done            = done_q;
    assign w_valid         = !fifo_empty;
    assign w_data          = mem[rd_ptr];
    assign fsm_state       = state_q;

`ifdef WEIGHT_FETCH_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (accept) begin
            stall_cnt <= '0;
        end else if ((state_q == S_FETCH) && !read_en_input && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Directed bench for weight_fetch_ctrl: command vector table plus hand sequences for overrun,
// idle strobes and mid-fetch reset, with a zero-latency read master model and beat scoreboard.
module tb_weight_fetch_ctrl;
  localparam int ADDR_W     = 17;
  localparam int DATA_W     = 1024;
  localparam int LEN_W      = 16;
  localparam int FIFO_DEPTH = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_base = '0;
  logic [LEN_W-1:0]  cmd_len = '0;
  logic [ADDR_W-1:0] addr_read_input;
  logic              read_en_input;
  logic [DATA_W-1:0] data_read = '0;
  logic              data_valid = 1'b0;
  logic [DATA_W-1:0] w_data;
  logic              w_valid;
  logic              w_ready = 1'b0;
  logic              busy;
  logic              done;
  logic [1:0]        fsm_state;
`ifdef WEIGHT_FETCH_STALL_CNT_EN
  logic [31:0]       stall_cnt;
`endif

  weight_fetch_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_base(cmd_base), .cmd_len(cmd_len),
    .addr_read_input(addr_read_input), .read_en_input(read_en_input),
    .data_read(data_read), .data_valid(data_valid),
    .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready),
    .busy(busy), .done(done), .fsm_state(fsm_state)
`ifdef WEIGHT_FETCH_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [DATA_W-1:0] exp_q[$];
  logic [ADDR_W-1:0] addr_exp_q[$];
  int issued, popped, max_fill, done_cnt;
  logic inj_dv = 1'b0;
  logic [DATA_W-1:0] inj_data = '0;

  typedef struct {
    logic [ADDR_W-1:0] base;
    logic [LEN_W-1:0]  len;
    int                hold;
    int                exp_max;
    int                exp_lat;
  } vec_t;
  vec_t vecs[7];

  function automatic logic [DATA_W-1:0] beat_of(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] b;
    b = '0;
    for (int i = 0; i < DATA_W / 32; i++) b[i*32 +: 32] = {15'(i), a} ^ 32'h5A5A_0000;
    return b;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_data(input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL beat_data: got low word %0h expected low word %0h (t=%0t)",
               act[63:0], exp[63:0], $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Read master model and output monitor, both on the falling edge.
  always @(negedge clk) begin
    data_valid = inj_dv | (rst_n & read_en_input);
    data_read  = inj_dv ? inj_data : beat_of(addr_read_input);
    if (rst_n) begin
      if (read_en_input) begin
        issued++;
        if (addr_exp_q.size() == 0) check("spurious_read", 64'(addr_read_input), 64'h0);
        else check("read_addr", 64'(addr_read_input), 64'(addr_exp_q.pop_front()));
      end
      if (w_valid && w_ready) begin
        popped++;
        if (exp_q.size() == 0) check("extra_beat", 64'(1), 64'(0));
        else check_data(w_data, exp_q.pop_front());
      end
      if (issued - popped > max_fill) max_fill = issued - popped;
      if (done) done_cnt++;
    end
  end

  task automatic clear_stats();
    issued = 0; popped = 0; max_fill = 0; done_cnt = 0;
  endtask

  task automatic expect_cmd(input logic [ADDR_W-1:0] base, input logic [LEN_W-1:0] len);
    for (int i = 0; i < int'(len); i++) begin
      addr_exp_q.push_back(base + ADDR_W'(i));
      exp_q.push_back(beat_of(base + ADDR_W'(i)));
    end
  endtask

  task automatic issue_cmd(input logic [ADDR_W-1:0] base, input logic [LEN_W-1:0] len);
    check("cmd_ready_idle", 64'(cmd_ready), 64'(1));
    cmd_base = base; cmd_len = len; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    check("busy_after_accept", 64'(busy), 64'(1));
  endtask

  task automatic wait_done(input int hold, input logic [LEN_W-1:0] len, output int n, output bit seen);
    n = 0; seen = 0;
    while (!seen && n < 400) begin
      if (hold > 0 && n == hold) begin
        if (len >= 6) check("read_en_throttled", 64'(read_en_input), 64'(0));
        w_ready = 1'b1;
      end
      tick();
      n++;
      if (done) seen = 1;
    end
    check("done_seen", 64'(seen), 64'(1));
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    bit seen;
    clear_stats();
    expect_cmd(v.base, v.len);
    w_ready = (v.hold == 0);
    issue_cmd(v.base, v.len);
    wait_done(v.hold, v.len, n, seen);
    if (v.exp_lat > 0) check("done_latency", 64'(n), 64'(v.exp_lat));
    check("busy_at_done", 64'(busy), 64'(0));
    tick();
    check("done_one_cycle", 64'(done), 64'(0));
    check("done_count", 64'(done_cnt), 64'(1));
    check("beats_left", 64'(exp_q.size()), 64'(0));
    check("addrs_left", 64'(addr_exp_q.size()), 64'(0));
    check("beats_out", 64'(popped), 64'(v.len));
    check("max_fill", 64'(max_fill), 64'(v.exp_max));
  endtask

  initial begin
    int n;
    bit seen;
    #500000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    bit seen;
    vecs[0] = '{base: 17'h00100, len: 16'd4,  hold: 0,  exp_max: 1, exp_lat: 6};
    vecs[1] = '{base: 17'h1FFFE, len: 16'd3,  hold: 0,  exp_max: 1, exp_lat: 5};
    vecs[2] = '{base: 17'h00000, len: 16'd0,  hold: 0,  exp_max: 0, exp_lat: 1};
    vecs[3] = '{base: 17'h00040, len: 16'd20, hold: 40, exp_max: 6, exp_lat: 0};
    vecs[4] = '{base: 17'h1FFFC, len: 16'd9,  hold: 12, exp_max: 6, exp_lat: 0};
    vecs[5] = '{base: 17'h002A0, len: 16'd5,  hold: 15, exp_max: 5, exp_lat: 0};
    vecs[6] = '{base: 17'h00003, len: 16'd1,  hold: 0,  exp_max: 1, exp_lat: 3};
    clear_stats();

    #12;
    check("rst_cmd_ready", 64'(cmd_ready), 64'(1));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_w_valid", 64'(w_valid), 64'(0));
    check("rst_read_en", 64'(read_en_input), 64'(0));
    check("rst_addr", 64'(addr_read_input), 64'(0));
    check("rst_state", 64'(fsm_state), 64'(0));
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i]);
      tick();
    end

    // data_valid while idle must not enter the FIFO
    clear_stats();
    w_ready = 1'b1;
    inj_data = beat_of(17'h01234);
    inj_dv = 1'b1;
    repeat (3) tick();
    inj_dv = 1'b0;
    tick();
    check("idle_dv_w_valid", 64'(w_valid), 64'(0));
    check("idle_dv_busy", 64'(busy), 64'(0));
    check("idle_dv_popped", 64'(popped), 64'(0));

    // overrun beats after the last owed beat are discarded
    clear_stats();
    w_ready = 1'b0;
    expect_cmd(17'h00500, 16'd2);
    issue_cmd(17'h00500, 16'd2);
    tick(); tick();
    check("overrun_state_drain", 64'(fsm_state), 64'(2));
    inj_data = beat_of(17'h00502);
    inj_dv = 1'b1;
    tick(); tick();
    inj_dv = 1'b0;
    w_ready = 1'b1;
    wait_done(0, 16'd2, n, seen);
    tick();
    check("overrun_popped", 64'(popped), 64'(2));
    check("overrun_beats_left", 64'(exp_q.size()), 64'(0));
    check("overrun_done_count", 64'(done_cnt), 64'(1));

    // reset mid-fetch with three beats buffered
    clear_stats();
    w_ready = 1'b0;
    expect_cmd(17'h00800, 16'd10);
    issue_cmd(17'h00800, 16'd10);
    tick(); tick(); tick();
    check("pre_rst_w_valid", 64'(w_valid), 64'(1));
    check("pre_rst_issued", 64'(issued), 64'(3));
    rst_n = 1'b0;
    #1;
    check("mid_rst_w_valid", 64'(w_valid), 64'(0));
    check("mid_rst_cmd_ready", 64'(cmd_ready), 64'(1));
    check("mid_rst_read_en", 64'(read_en_input), 64'(0));
    exp_q.delete();
    addr_exp_q.delete();
    tick();
    check("mid_rst_no_done", 64'(done_cnt), 64'(0));
    rst_n = 1'b1;
    tick();
    run_vec('{base: 17'h00900, len: 16'd2, hold: 0, exp_max: 1, exp_lat: 4});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
